vga_fb_arbiter: RTL and testbench

- Shares one external asynchronous SRAM framebuffer (15-bit RGB555 words) between two requesters:
  - the scanout path, which needs a continuous pixel stream;
  - the host write port, driven by the motherboard bus decoder.
- Sequences every SRAM access as a two-cycle read or write.
- Prefetches scanout pixels into a small first-word-fall-through FIFO.
- Sits between the VGA timing generator / pixel mux and the SRAM pins.

---
 rtl/vga_fb_arbiter_if.sv | 38 +++
 rtl/vga_fb_arbiter.sv | 139 +++++++++++++
 tb/tb_vga_fb_arbiter.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_fb_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vga_fb_arbiter_if : scanout, host-write and SRAM pad signals of the arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
interface vga_fb_arbiter_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 15
);
  logic              frame_start;
  logic              pix_pop;
  logic              pix_valid;
  logic [DATA_W-1:0] pix_data;
  logic              underflow;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_dout;
  logic              sram_oe;
  logic [DATA_W-1:0] sram_din;
  logic              sram_oe_n;
  logic              sram_we_n;

  modport slave (
    input  frame_start, pix_pop, wr_req, wr_addr, wr_data, sram_din,
    output pix_valid, pix_data, underflow, wr_ack,
           sram_addr, sram_dout, sram_oe, sram_oe_n, sram_we_n
  );

  modport master (
    output frame_start, pix_pop, wr_req, wr_addr, wr_data, sram_din,
    input  pix_valid, pix_data, underflow, wr_ack,
           sram_addr, sram_dout, sram_oe, sram_oe_n, sram_we_n
  );
endinterface
`default_nettype wire

// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vga_fb_arbiter : SRAM framebuffer arbiter, scanout prefetch FIFO vs host writes
// Rev 1.0
// ---------------------------------------------------------------------------
module vga_fb_arbiter #(
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 15,
  parameter int FIFO_DEPTH = 16,
  parameter int LOW_WATER  = 8,
  parameter int FB_WORDS   = 256000
) (
  input  logic             input_clk,
  input  logic             rst,
  vga_fb_arbiter_if.slave  bus
);

  localparam int                c_ptr_w    = $clog2(FIFO_DEPTH);
  localparam logic [c_ptr_w:0]  c_low      = (c_ptr_w+1)'(LOW_WATER);
  localparam logic [c_ptr_w:0]  c_depth    = (c_ptr_w+1)'(FIFO_DEPTH);
  localparam logic [c_ptr_w:0]  c_cnt_one  = (c_ptr_w+1)'(1);
  localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
  localparam logic [ADDR_W:0]   c_fb_words = (ADDR_W+1)'(FB_WORDS);
  localparam logic [ADDR_W-1:0] c_addr_one = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD0  = 3'd1,
    S_RD1  = 3'd2,
    S_WR0  = 3'd3,
    S_WR1  = 3'd4
  } state_t;

  state_t              r_state, w_next;
  logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0]  r_wptr, r_rptr;
  logic [c_ptr_w:0]    r_count, w_occ;
  logic [ADDR_W-1:0]   r_rd_addr, r_sram_addr;
  logic [DATA_W-1:0]   r_sram_dout;
  logic                r_underflow, r_wblock, r_discard;
  logic                w_rd_busy, w_rd_avail, w_wblock;
  logic                w_rd_issue, w_wr_issue, w_push, w_pop;

  assign w_rd_busy  = (r_state == S_RD0) || (r_state == S_RD1);
  assign w_occ      = r_count + {{c_ptr_w{1'b0}}, w_rd_busy};
  // No read is issued on the frame_start edge, so rd_addr can be cleared cleanly.
  assign w_rd_avail = ({1'b0, r_rd_addr} < c_fb_words) && !bus.frame_start;
  // The ack cycle itself blocks too: the host still holds wr_req there.
  assign w_wblock   = r_wblock || (r_state == S_WR1);
  assign w_push     = (r_state == S_RD1) && !r_discard && !bus.frame_start;
  assign w_pop      = bus.pix_pop && (r_count != '0) && !bus.frame_start;

  always_ff @(posedge input_clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_rd_issue = 1'b0;
    w_wr_issue = 1'b0;
    case (r_state)
      S_RD0:   w_next = S_RD1;
      S_WR0:   w_next = S_WR1;
      default: begin
        w_next = S_IDLE;
        if (w_rd_avail && (w_occ < c_low)) begin
          w_next     = S_RD0;
          w_rd_issue = 1'b1;
        end else if (bus.wr_req && !w_wblock) begin
          w_next     = S_WR0;
          w_wr_issue = 1'b1;
        end else if (w_rd_avail && (w_occ < c_depth)) begin
          w_next     = S_RD0;
          w_rd_issue = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge input_clk) begin
    if (rst) begin
      r_rd_addr   <= '0;
      r_sram_addr <= '0;
      r_sram_dout <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_underflow <= 1'b0;
      r_wblock    <= 1'b0;
      r_discard   <= 1'b0;
    end else begin
      if (w_rd_issue) begin
        r_sram_addr <= r_rd_addr;
        r_rd_addr   <= r_rd_addr + c_addr_one;
      end else if (w_wr_issue) begin
        r_sram_addr <= bus.wr_addr;
        r_sram_dout <= bus.wr_data;
      end
      r_wblock <= (r_state == S_WR1);

      // A read caught in RD0 by frame_start still finishes, but its word is dropped.
      if (bus.frame_start)      r_discard <= (r_state == S_RD0);
      else if (r_state == S_RD1) r_discard <= 1'b0;

      if (bus.frame_start) begin
        r_rd_addr <= '0;
        r_wptr    <= '0;
        r_rptr    <= '0;
        r_count   <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + c_ptr_one;
        if (w_pop)  r_rptr <= r_rptr + c_ptr_one;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + c_cnt_one;
          2'b01:   r_count <= r_count - c_cnt_one;
          default: r_count <= r_count;
        endcase
        if (bus.pix_pop && (r_count == '0)) r_underflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge input_clk) begin
    if (w_push) r_mem[r_wptr] <= bus.sram_din;
  end

  assign bus.pix_valid = (r_count != '0);
  assign bus.pix_data  = bus.pix_valid ? r_mem[r_rptr] : '0;
  assign bus.underflow = r_underflow;
  assign bus.wr_ack    = (r_state == S_WR1);
  assign bus.sram_addr = r_sram_addr;
  assign bus.sram_dout = r_sram_dout;
  assign bus.sram_oe   = (r_state == S_WR0) || (r_state == S_WR1);
  assign bus.sram_oe_n = !w_rd_busy;
  assign bus.sram_we_n = (r_state != S_WR1);

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_vga_fb_arbiter : directed self-checking bench with an SRAM model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_vga_fb_arbiter;
  localparam int AW  = 18;
  localparam int DW  = 15;
  localparam int FBW = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   passed = 0;
  int   wr_cnt = 0;
  int   ack_cnt = 0;
  int   rd_q[$];
  logic [DW-1:0] wmem [int];
  logic          prev_oe_n = 1'b1;
  logic [AW-1:0] prev_addr = '0;

  vga_fb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  vga_fb_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(16), .LOW_WATER(8), .FB_WORDS(FBW)
  ) dut (
    .input_clk(clk),
    .rst      (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pat(input int a);
    int v;
    v = (a * 97) ^ 32'h2A5A;
    return v[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] model_rd(input int a);
    if (wmem.exists(a)) return wmem[a];
    return pat(a);
  endfunction

  // SRAM model and bus logger
  always @(negedge clk) begin
    if (!bus.sram_we_n) begin
      wr_cnt++;
      wmem[int'(bus.sram_addr)] = bus.sram_dout;
    end
    if (bus.wr_ack) ack_cnt++;
    if (!bus.sram_oe_n && (prev_oe_n || bus.sram_addr != prev_addr))
      rd_q.push_back(int'(bus.sram_addr));
    prev_oe_n = bus.sram_oe_n;
    prev_addr = bus.sram_addr;
    bus.sram_din = bus.sram_oe_n ? '0 : model_rd(int'(bus.sram_addr));
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.wr_req = 1'b0; bus.pix_pop = 1'b0; bus.frame_start = 1'b0;
    tick(); tick();
    rd_q.delete(); wr_cnt = 0; ack_cnt = 0;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.wr_req = 1'b0; bus.pix_pop = 1'b0; bus.frame_start = 1'b0;
    bus.wr_addr = '0; bus.wr_data = '0;
    tick(); tick();
    total++; if ({bus.sram_oe_n, bus.sram_we_n, bus.sram_oe} !== 3'b110)
      $display("FAIL reset_ctl: got %b want 110", {bus.sram_oe_n, bus.sram_we_n, bus.sram_oe}); else passed++;
    total++; if (bus.sram_addr !== '0) $display("FAIL reset_addr: got %h want 0", bus.sram_addr); else passed++;
    total++; if ({bus.wr_ack, bus.pix_valid, bus.underflow} !== 3'b000)
      $display("FAIL reset_flags: got %b want 000", {bus.wr_ack, bus.pix_valid, bus.underflow}); else passed++;
    total++; if (bus.pix_data !== '0) $display("FAIL reset_pix_data: got %h want 0", bus.pix_data); else passed++;
    rd_q.delete(); wr_cnt = 0; ack_cnt = 0;
    rst = 1'b0;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 32; i++) tick();
    total++; if (rd_q.size() != 16 || bus.sram_oe_n !== 1'b0)
      $display("FAIL fill_at32: reads %0d oe_n %b want 16 0", rd_q.size(), bus.sram_oe_n); else passed++;
    tick();
    total++; if (bus.sram_oe_n !== 1'b1) $display("FAIL fill_idle: oe_n %b want 1", bus.sram_oe_n); else passed++;
    total++; if (bus.pix_valid !== 1'b1 || bus.pix_data !== pat(0))
      $display("FAIL fill_head: valid %b data %h want 1 %h", bus.pix_valid, bus.pix_data, pat(0)); else passed++;
    for (int i = 0; i < 8; i++) tick();
    total++; if (rd_q.size() != 16) $display("FAIL fill_stop: reads %0d want 16", rd_q.size()); else passed++;
    for (int i = 0; i < 16; i++) begin
      total++; if (((i < rd_q.size()) ? rd_q[i] : -1) != i)
        $display("FAIL fill_addr%0d: got %0d want %0d", i, (i < rd_q.size()) ? rd_q[i] : -1, i); else passed++;
    end
  endtask

  task automatic test_write();
    bus.wr_req = 1'b1; bus.wr_addr = 18'h00123; bus.wr_data = 15'h7C00;
    tick();
    total++; if ({bus.sram_oe, bus.sram_we_n, bus.wr_ack} !== 3'b110 || bus.sram_addr !== 18'h00123 || bus.sram_dout !== 15'h7C00)
      $display("FAIL wr0: oe/we_n/ack %b addr %h dout %h want 110 00123 7c00",
               {bus.sram_oe, bus.sram_we_n, bus.wr_ack}, bus.sram_addr, bus.sram_dout); else passed++;
    tick();
    total++; if ({bus.sram_oe, bus.sram_we_n, bus.wr_ack} !== 3'b101)
      $display("FAIL wr1: oe/we_n/ack %b want 101", {bus.sram_oe, bus.sram_we_n, bus.wr_ack}); else passed++;
    tick();
    total++; if (bus.wr_ack !== 1'b0 || bus.sram_we_n !== 1'b1)
      $display("FAIL wr_after_ack: ack %b we_n %b want 0 1", bus.wr_ack, bus.sram_we_n); else passed++;
    bus.wr_req = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    total++; if (wr_cnt != 1 || ack_cnt != 1)
      $display("FAIL wr_once: writes %0d acks %0d want 1 1", wr_cnt, ack_cnt); else passed++;
    total++; if (model_rd(32'h123) !== 15'h7C00)
      $display("FAIL wr_mem: got %h want 7c00", model_rd(32'h123)); else passed++;
    for (int i = 0; i < 16; i++) begin
      total++; if (bus.pix_valid !== 1'b1 || bus.pix_data !== pat(i))
        $display("FAIL pop%0d: valid %b data %h want 1 %h", i, bus.pix_valid, bus.pix_data, pat(i)); else passed++;
      bus.pix_pop = 1'b1;
      tick();
    end
    bus.pix_pop = 1'b0;
  endtask

  task automatic test_priority();
    bit got = 0;
    int rd_at_ack = -1;
    do_reset();
    bus.wr_req = 1'b1; bus.wr_addr = 18'h00200; bus.wr_data = 15'h03E0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      if (bus.wr_ack) begin got = 1; rd_at_ack = rd_q.size(); end
    end
    total++; if (!got || rd_at_ack != 8)
      $display("FAIL prio_grant: ack %0d reads_before %0d want 1 8", got, rd_at_ack); else passed++;
    tick();
    bus.wr_req = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    total++; if (wr_cnt != 1 || ack_cnt != 1 || rd_q.size() != 16)
      $display("FAIL prio_totals: writes %0d acks %0d reads %0d want 1 1 16", wr_cnt, ack_cnt, rd_q.size()); else passed++;
    total++; if (model_rd(32'h200) !== 15'h03E0 || bus.underflow !== 1'b0)
      $display("FAIL prio_mem: mem %h uf %b want 03e0 0", model_rd(32'h200), bus.underflow); else passed++;
  endtask

  task automatic test_frame_flush();
    int hits = 0;
    int idx = -1;
    do_reset();
    for (int i = 0; i < 200 && hits < 2; i++) begin
      bus.pix_pop = bus.pix_valid;
      if (!bus.sram_oe_n && bus.sram_addr == 18'd40) hits++;
      if (hits < 2) tick();
    end
    total++; if (hits != 2) $display("FAIL flush_trigger: hits %0d want 2", hits); else passed++;
    idx = rd_q.size();
    bus.frame_start = 1'b1; bus.pix_pop = 1'b1;
    tick();
    bus.frame_start = 1'b0; bus.pix_pop = 1'b0;
    total++; if (bus.pix_valid !== 1'b0 || bus.underflow !== 1'b0)
      $display("FAIL flush_empty: valid %b uf %b want 0 0", bus.pix_valid, bus.underflow); else passed++;
    for (int i = 0; i < 10 && rd_q.size() <= idx; i++) tick();
    total++; if (((idx < rd_q.size()) ? rd_q[idx] : -1) != 0)
      $display("FAIL flush_restart: next read %0d want 0", (idx < rd_q.size()) ? rd_q[idx] : -1); else passed++;
    for (int i = 0; i < 2; i++) tick();
    total++; if (bus.pix_valid !== 1'b1 || bus.pix_data !== pat(0))
      $display("FAIL flush_head: valid %b data %h want 1 %h", bus.pix_valid, bus.pix_data, pat(0)); else passed++;
  endtask

  task automatic test_underflow();
    do_reset();
    bus.pix_pop = 1'b1;
    tick();
    bus.pix_pop = 1'b0;
    total++; if (bus.underflow !== 1'b1 || bus.pix_valid !== 1'b0)
      $display("FAIL uf_set: uf %b valid %b want 1 0", bus.underflow, bus.pix_valid); else passed++;
    for (int i = 0; i < 40; i++) tick();
    total++; if (bus.underflow !== 1'b1 || rd_q.size() != 16)
      $display("FAIL uf_sticky: uf %b reads %0d want 1 16", bus.underflow, rd_q.size()); else passed++;
  endtask

  task automatic test_reset_mid_write();
    int w0;
    int a0;
    bus.wr_req = 1'b1; bus.wr_addr = 18'h00300; bus.wr_data = 15'h001F;
    tick();
    tick();
    total++; if (bus.wr_ack !== 1'b1) $display("FAIL rstwr1_in_wr1: ack %b want 1", bus.wr_ack); else passed++;
    rst = 1'b1;
    tick();
    total++; if ({bus.sram_we_n, bus.wr_ack, bus.sram_oe, bus.underflow} !== 4'b1000)
      $display("FAIL rstwr1_after: we_n/ack/oe/uf %b want 1000",
               {bus.sram_we_n, bus.wr_ack, bus.sram_oe, bus.underflow}); else passed++;
    rst = 1'b0; bus.wr_req = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    w0 = wr_cnt; a0 = ack_cnt;
    bus.wr_req = 1'b1; bus.wr_addr = 18'h00301; bus.wr_data = 15'h1234;
    tick();
    rst = 1'b1; bus.wr_req = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    total++; if (wr_cnt != w0 || ack_cnt != a0)
      $display("FAIL rstwr0_abandon: writes %0d acks %0d want %0d %0d", wr_cnt, ack_cnt, w0, a0); else passed++;
  endtask

  task automatic test_frame_end();
    int pops = 0;
    logic [DW-1:0] last = '0;
    do_reset();
    for (int i = 0; i < 200; i++) begin
      if (bus.pix_valid) begin last = bus.pix_data; pops++; bus.pix_pop = 1'b1; end
      else bus.pix_pop = 1'b0;
      tick();
    end
    bus.pix_pop = 1'b0;
    total++; if (rd_q.size() != FBW || ((rd_q.size() > 0) ? rd_q[rd_q.size()-1] : -1) != FBW-1)
      $display("FAIL end_reads: reads %0d last %0d want %0d %0d", rd_q.size(),
               (rd_q.size() > 0) ? rd_q[rd_q.size()-1] : -1, FBW, FBW-1); else passed++;
    total++; if (pops != FBW || last !== pat(FBW-1))
      $display("FAIL end_pops: pops %0d last %h want %0d %h", pops, last, FBW, pat(FBW-1)); else passed++;
    total++; if ({bus.pix_valid, bus.underflow, bus.sram_oe_n} !== 3'b001)
      $display("FAIL end_idle: valid/uf/oe_n %b want 001", {bus.pix_valid, bus.underflow, bus.sram_oe_n}); else passed++;
    for (int i = 0; i < 20; i++) tick();
    total++; if (rd_q.size() != FBW) $display("FAIL end_hold: reads %0d want %0d", rd_q.size(), FBW); else passed++;
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    for (int i = 0; i < 10 && rd_q.size() <= FBW; i++) tick();
    total++; if (((rd_q.size() > FBW) ? rd_q[FBW] : -1) != 0)
      $display("FAIL end_restart: next read %0d want 0", (rd_q.size() > FBW) ? rd_q[FBW] : -1); else passed++;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_write();
    test_priority();
    test_frame_flush();
    test_underflow();
    test_reset_mid_write();
    test_frame_end();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, total);
    $fatal(1);
  end
endmodule
`default_nettype wire
